// File: rtl/instr_encode_if.sv
// Field-input / encoded-word-output bus of the RV32I instruction encoder.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface instr_encode_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [6:0]        op_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  in_valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, instr_o, addr_o, illegal_o, count_o
  );

  modport master (
    output in_valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, addr_o, illegal_o, count_o
  );
endinterface

// File: rtl/instr_encode.sv
// Assembles RV32I instruction words from discrete fields and emits them through a
// one-deep valid/ready register, tagging each word with a sequential imem address.
module instr_encode #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  instr_encode_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic              out_valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              illegal_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [CNT_W-1:0]  count_q;

  logic [31:0] enc_instr;
  logic        enc_illegal;
  logic [31:0] imm;
  logic        in_ready;
  logic        in_accept;
  logic        out_accept;

  assign imm        = bus.imm_i;
  assign in_ready   = !out_valid_q || bus.out_ready_i;
  assign in_accept  = bus.in_valid_i && in_ready;
  assign out_accept = out_valid_q && bus.out_ready_i;

  // Format selection by opcode; unsupported opcodes become a flagged NOP.
  always_comb begin
    enc_instr   = NOP_INSTR;
    enc_illegal = 1'b0;
    case (bus.op_i)
      OP_R: begin
        enc_instr = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
      end
      OP_IMM: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (bus.funct3_i == 3'b001 || bus.funct3_i == 3'b101) begin
          enc_instr = {bus.funct7_i, imm[4:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
        end else begin
          enc_instr = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        enc_instr = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
      end
      OP_STORE: begin
        enc_instr = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.op_i};
      end
      OP_BRANCH: begin
        enc_instr = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                     imm[4:1], imm[11], bus.op_i};
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {imm[31:12], bus.rd_i, bus.op_i};
      end
      OP_JAL: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.op_i};
      end
      default: begin
        enc_instr   = NOP_INSTR;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Output register: loads on input accept, drains on output accept, otherwise holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      illegal_q   <= 1'b0;
      next_addr_q <= BASE_ADDR;
    end else begin
      if (in_accept) begin
        out_valid_q <= 1'b1;
        instr_q     <= enc_instr;
        addr_q      <= next_addr_q;
        illegal_q   <= enc_illegal;
        next_addr_q <= next_addr_q + ADDR_STEP;
      end else if (out_accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Saturating count of words taken by the consumer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (out_accept && count_q != CNT_MAX) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.instr_o     = instr_q;
  assign bus.addr_o      = addr_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.count_o     = count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Scoreboard bench for instr_encode: expected words are queued at input accept
// and compared when the consumer takes them; a narrow instance covers wrap/saturation.
module tb_instr_encode;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encode_if #(.ADDR_W(32), .CNT_W(16)) bus ();
  instr_encode_if #(.ADDR_W(4),  .CNT_W(2))  busw ();

  instr_encode #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  instr_encode #(.ADDR_W(4), .BASE_ADDR(4'd12), .CNT_W(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .bus(busw)
  );

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t q[$];
  exp_t qw[$];
  logic [31:0] exp_addr   = 32'h0;
  logic [3:0]  exp_addr_w = 4'd12;

  always @(posedge clk) cyc <= cyc + 1;

  // Main-instance scoreboard: compare each word the consumer takes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      tests++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got instr=%h addr=%h, expected no word", bus.instr_o, bus.addr_o);
      end else begin
        e = q.pop_front();
        if (bus.instr_o !== e.instr || bus.addr_o !== e.addr || bus.illegal_o !== e.ill) begin
          errors++;
          $display("FAIL word: got instr=%h addr=%h ill=%b, expected instr=%h addr=%h ill=%b",
                   bus.instr_o, bus.addr_o, bus.illegal_o, e.instr, e.addr, e.ill);
        end
      end
    end
  end

  // Narrow-instance scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && busw.out_valid_o && busw.out_ready_i) begin
      tests++;
      if (qw.size() == 0) begin
        errors++;
        $display("FAIL wword_unexpected: got instr=%h addr=%h, expected no word", busw.instr_o, busw.addr_o);
      end else begin
        e = qw.pop_front();
        if (busw.instr_o !== e.instr || 32'(busw.addr_o) !== e.addr || busw.illegal_o !== e.ill) begin
          errors++;
          $display("FAIL wword: got instr=%h addr=%h ill=%b, expected instr=%h addr=%h ill=%b",
                   busw.instr_o, busw.addr_o, busw.illegal_o, e.instr, e.addr, e.ill);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ei, input logic eill);
    int n;
    exp_t e;
    bus.op_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
    bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
    bus.in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.in_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready_o, n);
    end else begin
      e.instr = ei; e.addr = exp_addr; e.ill = eill;
      q.push_back(e);
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [31:0] ei);
    int n;
    exp_t e;
    busw.op_i = op; busw.rd_i = rd; busw.rs1_i = 5'd0; busw.rs2_i = 5'd0;
    busw.funct3_i = 3'd0; busw.funct7_i = 7'd0; busw.imm_i = imm;
    busw.in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (busw.in_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busw.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_w_timeout: in_ready=%b after %0d cycles, expected 1", busw.in_ready_o, n);
    end else begin
      e.instr = ei; e.addr = 32'(exp_addr_w); e.ill = 1'b0;
      qw.push_back(e);
      exp_addr_w = exp_addr_w + 4'd4;
    end
    @(posedge clk);
    #1;
    busw.in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;  busw.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1; busw.out_ready_i = 1'b1;
    bus.op_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    busw.op_i = '0; busw.rd_i = '0; busw.rs1_i = '0; busw.rs2_i = '0;
    busw.funct3_i = '0; busw.funct7_i = '0; busw.imm_i = '0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); qw.delete();
    exp_addr = 32'h0; exp_addr_w = 4'd12;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0; busw.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0; busw.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b instr=%h ill=%b, expected 0 0 0", bus.out_valid_o, bus.instr_o, bus.illegal_o);
    end
    tests++;
    if (bus.addr_o !== 32'h0 || bus.count_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_addr_count: got addr=%h count=%0d, expected 0 0", bus.addr_o, bus.count_o);
    end
    tests++;
    if (busw.addr_o !== 4'd12 || busw.count_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_base_addr: got addr=%0d count=%0d, expected 12 0", busw.addr_o, busw.count_o);
    end
    tests++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B3, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.count_o !== 16'd1) begin
      errors++;
      $display("FAIL single_count: got %0d, expected 1", bus.count_o);
    end
    tests++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL single_pending: got %0d undelivered, expected 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    int start;
    int elapsed;
    do_reset();
    start = cyc;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 1'b0);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h008000EF, 1'b0);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    elapsed = cyc - start;
    tests++;
    if (elapsed != 5) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles for 5 words, expected 5", elapsed);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.count_o !== 16'd5 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got count=%0d pending=%0d, expected 5 0", bus.count_o, q.size());
    end
  endtask

  task automatic test_formats();
    do_reset();
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'b0000000, 32'hFFFFFFE3, 32'h00311093, 1'b0);
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3,        32'h40315093, 1'b0);
    send(7'b0000011, 5'd4, 5'd3, 5'd0, 3'b010, 7'd0,       32'hFFFFFFF8, 32'hFF81A203, 1'b0);
    send(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0,   7'd0,       32'h0,        32'h00008067, 1'b0);
    send(7'b1110011, 5'd0, 5'd0, 5'd0, 3'd0,   7'd0,       32'h1,        32'h00100073, 1'b0);
    send(7'b0010111, 5'd7, 5'd0, 5'd0, 3'd0,   7'd0,       32'hABCDE123, 32'hABCDE397, 1'b0);
    send(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0,   7'b0100000, 32'h0,        32'h407302B3, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL formats_pending: got %0d undelivered, expected 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready_i = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    fork
      send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B3, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'h00500093 ||
              bus.addr_o !== 32'h0 || bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b instr=%h addr=%h in_ready=%b, expected 1 00500093 0 0",
                     bus.out_valid_o, bus.instr_o, bus.addr_o, bus.in_ready_o);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    tests++;
    if (bus.count_o !== 16'd2 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_delivery: got count=%0d pending=%0d, expected 2 0", bus.count_o, q.size());
    end
  endtask

  task automatic test_illegal();
    do_reset();
    send(7'b0000000, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000013, 1'b1);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd5,        32'h00500093, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.count_o !== 16'd2 || q.size() != 0) begin
      errors++;
      $display("FAIL illegal_count: got count=%0d pending=%0d, expected 2 0", bus.count_o, q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B3, 1'b0);
    @(negedge clk);
    tests++;
    if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 32'd4 || bus.count_o !== 16'd1) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b addr=%h count=%0d, expected 1 4 1",
               bus.out_valid_o, bus.addr_o, bus.count_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.out_valid_o !== 1'b0 || bus.addr_o !== 32'h0 || bus.count_o !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b addr=%h count=%0d, expected 0 0 0",
               bus.out_valid_o, bus.addr_o, bus.count_o);
    end
    q.delete();
    exp_addr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.count_o !== 16'd1 || q.size() != 0) begin
      errors++;
      $display("FAIL midrst_post: got count=%0d pending=%0d, expected 1 0", bus.count_o, q.size());
    end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_w(7'b0010011, 5'(i + 1), 32'd5, 32'h00500013 | (32'(i + 1) << 7));
    end
    repeat (2) @(negedge clk);
    tests++;
    if (busw.count_o !== 2'd3) begin
      errors++;
      $display("FAIL wrap_count_sat: got %0d, expected 3", busw.count_o);
    end
    tests++;
    if (qw.size() != 0 || busw.addr_o !== 4'd12) begin
      errors++;
      $display("FAIL wrap_last_addr: got pending=%0d addr=%0d, expected 0 12", qw.size(), busw.addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_wrap_saturate();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
- Inverse of the instruction field decoder: assembles RV32I base-ISA instructions from discrete fields into 32-bit words.
- Formats each word by instruction type (R/I/S/B/U/J), selected from the opcode.
- Emits words through a one-deep registered valid/ready stage, each tagged with a sequential instruction-memory address.
- Used by the test/program-loader path to fill instruction memory and to cross-check the decoder.

Parameters:
- ADDR_W, 32, width of the address counter and of addr_o.
- BASE_ADDR, 32'h0000_0000, address tagged on the first emitted word after reset.
- CNT_W, 16, width of the saturating emitted-word counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  input fields are valid.
- in_ready_o  output  1  encoder can accept the input fields this cycle.
- op_i  input  7  opcode.
- rd_i  input  5  destination register.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field.
- imm_i  input  32  immediate, sign-extended byte value as the ISA defines it.
- out_valid_o  output  1  instr_o/addr_o/illegal_o hold a word.
- out_ready_i  input  1  downstream consumer accepts the word.
- instr_o  output  32  encoded instruction.
- addr_o  output  ADDR_W  address tagged on instr_o.
- illegal_o  output  1  opcode was unsupported; instr_o is a NOP.
- count_o  output  CNT_W  number of words accepted downstream.

Behaviour:
- Reset (async assert, values held while rst_i=1):
  - out_valid_o=0, instr_o=0, illegal_o=0, addr_o=BASE_ADDR, count_o=0.
  - Asserting reset mid-operation discards any held word.
- Handshakes:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Input accepted when in_valid_i && in_ready_o; output accepted when out_valid_o && out_ready_i.
- Latency: one cycle. Fields accepted at edge N appear on instr_o after edge N, with out_valid_o=1.
- Output register:
  - Holds instr_o, addr_o and illegal_o stable while out_valid_o && !out_ready_i.
  - Output accept with no new input: out_valid_o clears.
  - Output accept and input accept in the same cycle: the register reloads and out_valid_o stays 1, giving full throughput.
- Encoding by op_i (concatenation, MSB first):
  - R, 0110011: funct7, rs2, rs1, funct3, rd, op.
  - I, ops 0010011/0000011/1100111/1110011: imm[11:0], rs1, funct3, rd, op.
    - Exception: op 0010011 with funct3 001 or 101 encodes as funct7, imm[4:0], rs1, funct3, rd, op.
  - S, 0100011: imm[11:5], rs2, rs1, funct3, imm[4:0], op.
  - B, 1100011: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op.
  - U, ops 0110111/0010111: imm[31:12], rd, op.
  - J, 1101111: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - Any other op: instr = 32'h0000_0013 (addi x0,x0,0) and illegal_o=1.
  - Immediate bits not listed for a format are ignored; there is no range check.
- Address tagging:
  - Internal next-address counter starts at BASE_ADDR.
  - On each input accept, the word is tagged with the counter value and the counter advances by 4, modulo 2^ADDR_W (wraps silently).
  - Illegal words consume an address.
- count_o increments on each output accept and saturates at 2^CNT_W-1.

Test Plan:
1. Reset, then send add x3,x1,x2 (op 0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0) with out_ready_i=1 -> next cycle instr_o=0x002081B3, addr_o=0, illegal_o=0; count_o=1 after the output accept.
2. Back-to-back stream with out_ready_i=1: addi x1,x0,5 -> 0x00500093; sw x2,8(x1) -> 0x0020A423; beq x1,x2,imm=0xFFFFFFFC -> 0xFE208EE3; jal x1,8 -> 0x008000EF; lui x5,imm=0x12345000 -> 0x123452B7.
   - One word per cycle, addr_o 0,4,8,12,16, count_o=5 at the end.
3. Backpressure: out_ready_i=0 for 3 cycles with two inputs presented.
   - First word is held stable and in_ready_o=0; second input stays pending.
   - Release out_ready_i -> words delivered in order with addr_o 0 then 4, no loss or duplication.
4. Illegal op 0000000 -> instr_o=0x00000013, illegal_o=1, address advances by 4. A following legal word has illegal_o=0.
5. Assert rst_i asynchronously while a word is held and out_ready_i=0 -> out_valid_o drops immediately, addr_o=BASE_ADDR, count_o=0. The next word after reset is tagged with BASE_ADDR.
6. Wrap and saturation, with ADDR_W=4, BASE_ADDR=12, CNT_W=2: five accepted words -> addr_o 12,0,4,8,12 and count_o saturates at 3.
